// File: rtl/conv_sr_stride_multik_dpath_if.sv
// rtl/conv_sr_stride_multik_dpath_if.sv - column stream and result write port bundle
interface conv_sr_stride_multik_dpath_if #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int IMG_D      = 4,
    parameter int FILTER_L   = 3,
    parameter int FILTER_K   = 4,
    parameter int STRIDE_W   = 1,
    parameter int STRIDE_H   = 1
);
    localparam int RESULT_W = (IMG_W - FILTER_L) / STRIDE_W + 1;
    localparam int RESULT_H = (IMG_H - FILTER_L) / STRIDE_H + 1;
    localparam int RA_W     = $clog2(RESULT_W * RESULT_H);
    localparam int K_W      = (FILTER_K > 1) ? $clog2(FILTER_K) : 1;
    localparam int OFF_W    = (FILTER_L > 1) ? $clog2(FILTER_L) : 1;

    logic                                  frame_start;
    logic                                  row_start;
    logic                                  row_emit;
    logic [OFF_W-1:0]                      rotation_offset;
    logic [DATA_WIDTH*IMG_D*FILTER_L-1:0]  col_data;
    logic                                  col_valid;
    logic                                  col_ready;
    logic signed [DATA_WIDTH-1:0]          result_data;
    logic [RA_W-1:0]                       result_addr;
    logic [K_W-1:0]                        result_k;
    logic                                  result_valid;
    logic                                  last_val;

    modport slave (
        input  frame_start, row_start, row_emit, rotation_offset, col_data, col_valid,
        output col_ready, result_data, result_addr, result_k, result_valid, last_val
    );

    modport master (
        output frame_start, row_start, row_emit, rotation_offset, col_data, col_valid,
        input  col_ready, result_data, result_addr, result_k, result_valid, last_val
    );
endinterface

// File: rtl/conv_sr_stride_multik_dpath.sv
// rtl/conv_sr_stride_multik_dpath.sv - strided sliding-window convolution, FILTER_K filters on one 3-stage MAC
// Weight n of filter k sits at fil[(k*N+n)*DW +: DW], n = (channel*FILTER_L + row)*FILTER_L + col, col 0 = oldest column.
module conv_sr_stride_multik_dpath #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int IMG_D      = 4,
    parameter int FILTER_L   = 3,
    parameter int FILTER_K   = 4,
    parameter int STRIDE_W   = 1,
    parameter int STRIDE_H   = 1,
    parameter int OUT_SHIFT  = 0,
    parameter int RELU       = 0
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic [DATA_WIDTH*IMG_D*FILTER_L*FILTER_L*FILTER_K-1:0]  fil,
    conv_sr_stride_multik_dpath_if.slave                            bus
);
    localparam int N        = IMG_D * FILTER_L * FILTER_L;
    localparam int RESULT_W = (IMG_W - FILTER_L) / STRIDE_W + 1;
    localparam int RESULT_H = (IMG_H - FILTER_L) / STRIDE_H + 1;
    localparam int ACC_W    = 2 * DATA_WIDTH + $clog2(N);
    localparam int RA_W     = $clog2(RESULT_W * RESULT_H);
    localparam int K_W      = (FILTER_K > 1) ? $clog2(FILTER_K) : 1;
    localparam int CNT_W    = $clog2(IMG_W + 1);
    localparam int PW       = 2 * DATA_WIDTH;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {LOAD, SWEEP} state_t;

    state_t                        state_q, state_d;
    logic [K_W-1:0]                k_q, k_d;
    logic [CNT_W-1:0]              col_cnt_q, col_cnt_d, cnt_upd;
    logic [RA_W-1:0]               ox_q, ox_d, oy_q, oy_d;
    logic                          accept, eligible, issue;
    logic [RA_W-1:0]               addr_issue;
    logic signed [DATA_WIDTH-1:0]  win_q [IMG_D][FILTER_L][FILTER_L];
    logic signed [DATA_WIDTH-1:0]  rot [IMG_D][FILTER_L];

    logic signed [PW-1:0]          prod_q [N];
    logic                          v1_q, v2_q;
    logic [RA_W-1:0]               a1_q, a2_q;
    logic [K_W-1:0]                k1_q, k2_q;
    logic signed [ACC_W-1:0]       acc_q, sum, shifted;
    logic signed [DATA_WIDTH-1:0]  sat;
    logic signed [DATA_WIDTH-1:0]  res_data_q;
    logic [RA_W-1:0]               res_addr_q;
    logic [K_W-1:0]                res_k_q;
    logic                          res_valid_q, last_q;

    assign accept        = (state_q == LOAD) && bus.col_valid;
    assign issue         = (state_q == SWEEP);
    assign bus.col_ready = (state_q == LOAD);
    assign addr_issue    = RA_W'(int'(oy_q) * RESULT_W + int'(ox_q));

    // Undo the BRAM bank rotation so element i is always the i-th window row.
    always_comb begin
        for (int c = 0; c < IMG_D; c++)
            for (int i = 0; i < FILTER_L; i++)
                rot[c][i] = bus.col_data[(c*FILTER_L + (i + int'(bus.rotation_offset)) % FILTER_L)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        col_cnt_d = col_cnt_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        cnt_upd   = col_cnt_q;
        eligible  = 1'b0;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (bus.row_start)
                        cnt_upd = CNT_W'(1);
                    else if (col_cnt_q != CNT_W'(IMG_W))
                        cnt_upd = col_cnt_q + CNT_W'(1);
                    col_cnt_d = cnt_upd;
                end
                if (bus.frame_start) begin
                    col_cnt_d = '0;
                    ox_d      = '0;
                    oy_d      = '0;
                end
                eligible = accept && bus.row_emit && (int'(col_cnt_d) >= FILTER_L)
                           && ((int'(col_cnt_d) - FILTER_L) % STRIDE_W == 0);
                if (eligible) begin
                    state_d = SWEEP;
                    k_d     = '0;
                end
            end
            default: begin
                if (k_q == K_W'(FILTER_K - 1)) begin
                    state_d = LOAD;
                    k_d     = '0;
                    if (ox_q == RA_W'(RESULT_W - 1)) begin
                        ox_d = '0;
                        oy_d = (oy_q == RA_W'(RESULT_H - 1)) ? '0 : oy_q + RA_W'(1);
                    end else begin
                        ox_d = ox_q + RA_W'(1);
                    end
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOAD;
            k_q       <= '0;
            col_cnt_q <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            for (int c = 0; c < IMG_D; c++)
                for (int i = 0; i < FILTER_L; i++)
                    for (int j = 0; j < FILTER_L; j++)
                        win_q[c][i][j] <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            col_cnt_q <= col_cnt_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            if (accept) begin
                for (int c = 0; c < IMG_D; c++)
                    for (int i = 0; i < FILTER_L; i++) begin
                        for (int j = 0; j < FILTER_L - 1; j++)
                            win_q[c][i][j] <= win_q[c][i][j+1];
                        win_q[c][i][FILTER_L-1] <= rot[c][i];
                    end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int n = 0; n < N; n++)
            sum = sum + ACC_W'(prod_q[n]);
    end

    always_comb begin
        shifted = acc_q >>> OUT_SHIFT;
        if (RELU != 0 && shifted[ACC_W-1])
            shifted = '0;
        if (shifted > SAT_MAX)
            sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            sat = SAT_MIN[DATA_WIDTH-1:0];
        else
            sat = shifted[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < N; n++)
                prod_q[n] <= '0;
            v1_q        <= 1'b0;
            a1_q        <= '0;
            k1_q        <= '0;
            acc_q       <= '0;
            v2_q        <= 1'b0;
            a2_q        <= '0;
            k2_q        <= '0;
            res_data_q  <= '0;
            res_addr_q  <= '0;
            res_k_q     <= '0;
            res_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            for (int c = 0; c < IMG_D; c++)
                for (int i = 0; i < FILTER_L; i++)
                    for (int j = 0; j < FILTER_L; j++)
                        prod_q[(c*FILTER_L + i)*FILTER_L + j] <= PW'(win_q[c][i][j])
                            * PW'($signed(fil[(int'(k_q)*N + (c*FILTER_L + i)*FILTER_L + j)*DATA_WIDTH +: DATA_WIDTH]));
            v1_q        <= issue;
            a1_q        <= addr_issue;
            k1_q        <= k_q;
            acc_q       <= sum;
            v2_q        <= v1_q;
            a2_q        <= a1_q;
            k2_q        <= k1_q;
            res_data_q  <= sat;
            res_addr_q  <= a2_q;
            res_k_q     <= k2_q;
            res_valid_q <= v2_q;
            last_q      <= v2_q && (a2_q == RA_W'(RESULT_W * RESULT_H - 1)) && (k2_q == K_W'(FILTER_K - 1));
        end
    end

    assign bus.result_data  = res_data_q;
    assign bus.result_addr  = res_addr_q;
    assign bus.result_k     = res_k_q;
    assign bus.result_valid = res_valid_q;
    assign bus.last_val     = last_q;
endmodule

// File: tb/tb_conv_sr_stride_multik_dpath.sv
// tb/tb_conv_sr_stride_multik_dpath.sv - self-checking bench for conv_sr_stride_multik_dpath
module tb_conv_sr_stride_multik_dpath;
    localparam int DW = 12, W = 16, H = 16, D = 4, L = 3, K = 4, N = D*L*L;

    typedef struct {
        int data;
        int addr;
        int k;
        int last;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DW*N*K-1:0] fil;
    logic [DW*D*L-1:0] col_data;
    logic [1:0] off;
    logic frame_start, row_start, row_emit, col_valid;
    int sel;

    int img [D][H][W];
    int wt [K][N];
    exp_t q [2][$];
    int rlog [2][$];
    int nres [2];
    int nvalid [2];
    int nlast [2];
    int checks = 0, errors = 0, cyc = 0;
    bit prev_elig = 1'b0;

    logic rv [2], lv [2], rdy [2];
    int rd [2], ra [2], rk [2];

    conv_sr_stride_multik_dpath_if #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .IMG_D(D),
        .FILTER_L(L), .FILTER_K(K), .STRIDE_W(1), .STRIDE_H(1)) if0 ();
    conv_sr_stride_multik_dpath_if #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .IMG_D(D),
        .FILTER_L(L), .FILTER_K(K), .STRIDE_W(2), .STRIDE_H(2)) if1 ();

    conv_sr_stride_multik_dpath #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .IMG_D(D), .FILTER_L(L),
        .FILTER_K(K), .STRIDE_W(1), .STRIDE_H(1), .OUT_SHIFT(0), .RELU(0))
        u0 (.clk(clk), .reset(reset), .fil(fil), .bus(if0));
    conv_sr_stride_multik_dpath #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .IMG_D(D), .FILTER_L(L),
        .FILTER_K(K), .STRIDE_W(2), .STRIDE_H(2), .OUT_SHIFT(0), .RELU(1))
        u1 (.clk(clk), .reset(reset), .fil(fil), .bus(if1));

    assign if0.frame_start     = frame_start && (sel == 0);
    assign if1.frame_start     = frame_start && (sel == 1);
    assign if0.col_valid       = col_valid && (sel == 0);
    assign if1.col_valid       = col_valid && (sel == 1);
    assign if0.row_start       = row_start;
    assign if1.row_start       = row_start;
    assign if0.row_emit        = row_emit;
    assign if1.row_emit        = row_emit;
    assign if0.rotation_offset = off;
    assign if1.rotation_offset = off;
    assign if0.col_data        = col_data;
    assign if1.col_data        = col_data;

    assign rv[0] = if0.result_valid;  assign rv[1] = if1.result_valid;
    assign lv[0] = if0.last_val;      assign lv[1] = if1.last_val;
    assign rdy[0] = if0.col_ready;    assign rdy[1] = if1.col_ready;
    assign rd[0] = int'(if0.result_data);  assign rd[1] = int'(if1.result_data);
    assign ra[0] = int'(if0.result_addr);  assign ra[1] = int'(if1.result_addr);
    assign rk[0] = int'(if0.result_k);     assign rk[1] = int'(if1.result_k);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int stride_of(int s); return (s == 1) ? 2 : 1; endfunction
    function automatic int total_of(int s);  return (s == 1) ? 49 : 196; endfunction

    function automatic int sat_model(int acc, int relu);
        int v = acc;
        if (relu != 0 && v < 0) v = 0;
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Window whose bottom input row is r and whose rightmost column is image column x-1.
    function automatic int win_sum(int k, int r, int x);
        int s = 0;
        for (int c = 0; c < D; c++)
            for (int i = 0; i < L; i++)
                for (int j = 0; j < L; j++)
                    s += img[c][r-L+1+i][x-L+j] * wt[k][(c*L + i)*L + j];
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                if (rv[s]) begin
                    nvalid[s]++;
                    nlast[s] += int'(lv[s]);
                    rlog[s].push_back(rd[s]);
                    if (q[s].size() == 0) begin
                        chk($sformatf("u%0d_unexpected_result", s), 1, 0);
                    end else begin
                        e = q[s].pop_front();
                        chk($sformatf("u%0d_data", s), rd[s], e.data);
                        chk($sformatf("u%0d_addr", s), ra[s], e.addr);
                        chk($sformatf("u%0d_k", s), rk[s], e.k);
                        chk($sformatf("u%0d_last", s), int'(lv[s]), e.last);
                        chk($sformatf("u%0d_latency_cycle", s), cyc, e.cyc);
                    end
                end else if (lv[s]) begin
                    chk($sformatf("u%0d_last_without_valid", s), 1, 0);
                end
            end
        end
    end

    task automatic set_fil();
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                fil[(k*N + n)*DW +: DW] = DW'(wt[k][n]);
    endtask

    task automatic send_col(int s, int r, int x, bit rs, bit re, int o);
        int gap = 0;
        int rr;
        bit elig;
        exp_t e;
        for (int c = 0; c < D; c++)
            for (int i = 0; i < L; i++) begin
                rr = r - L + 1 + i;
                col_data[(c*L + (i + o) % L)*DW +: DW] = DW'((rr >= 0) ? img[c][rr][x-1] : 0);
            end
        sel = s; row_start = rs; row_emit = re; off = 2'(o); col_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy[s]) break;
            gap++;
            if (gap > 50) begin
                chk("ready_timeout", gap, K);
                break;
            end
        end
        @(posedge clk); #1;
        chk("ready_gap", gap, prev_elig ? K : 0);
        elig = re && x >= L && ((x - L) % stride_of(s) == 0);
        if (elig) begin
            for (int k = 0; k < K; k++) begin
                e.data = sat_model(win_sum(k, r, x), s);
                e.addr = nres[s] % total_of(s);
                e.k    = k;
                e.last = (e.addr == total_of(s) - 1 && k == K - 1) ? 1 : 0;
                e.cyc  = cyc + 3 + k;
                q[s].push_back(e);
            end
            nres[s]++;
        end
        prev_elig = elig;
    endtask

    task automatic drain();
        int t = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("drain_pending", q[0].size() + q[1].size(), 0);
        q[0].delete(); q[1].delete();
        prev_elig = 1'b0;
        #1;
    endtask

    task automatic frame_pulse(int s);
        sel = s; col_valid = 1'b0; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        nres[s] = 0;
        prev_elig = 1'b0;
    endtask

    task automatic send_rows(int s, int nrows, bit rotate);
        frame_pulse(s);
        for (int r = 0; r < nrows; r++)
            for (int x = 1; x <= W; x++)
                send_col(s, r, x, x == 1, r >= L - 1 && ((r - L + 1) % stride_of(s) == 0), rotate ? r % L : 0);
        col_valid = 1'b0;
        drain();
    endtask

    task automatic clear_stats();
        for (int s = 0; s < 2; s++) begin
            nvalid[s] = 0; nlast[s] = 0; rlog[s].delete();
        end
    endtask

    task automatic fill_pattern();
        for (int c = 0; c < D; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    img[c][y][x] = ((c*7 + y*3 + x*5) % 11) - 5;
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                wt[k][n] = ((n*5 + k*3) % 9) - 4;
        set_fil();
    endtask

    task automatic fill_ones_img();
        for (int c = 0; c < D; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    img[c][y][x] = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int bad, snap;
        sel = 0; frame_start = 0; row_start = 0; row_emit = 0; col_valid = 0; off = 0;
        col_data = '0; fil = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_col_ready", int'(rdy[0]), 1);
        chk("rst_result_valid", int'(rv[0]), 0);
        chk("rst_last_val", int'(lv[0]), 0);
        chk("rst_result_data", rd[0], 0);
        chk("rst_result_addr", ra[0], 0);
        chk("rst_result_k", rk[0], 0);
        chk("rst_u1_col_ready", int'(rdy[1]), 1);
        chk("rst_u1_result_valid", int'(rv[1]), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // All ones: every result of the 14x14 map is 36.
        fill_ones_img();
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                wt[k][n] = 1;
        set_fil();
        clear_stats();
        send_rows(0, H, 1'b0);
        chk("ones_result_count", nvalid[0], 784);
        chk("ones_last_count", nlast[0], 1);
        chk("ones_first_value", rlog[0].size() > 0 ? rlog[0][0] : -1, 36);
        bad = 0;
        foreach (rlog[0][i]) if (rlog[0][i] != 36) bad++;
        chk("ones_values_not_36", bad, 0);

        // Mixed-sign data, no rotation, then the same image with banks rotated per row.
        fill_pattern();
        clear_stats();
        send_rows(0, H, 1'b0);
        chk("pattern_result_count", nvalid[0], 784);
        clear_stats();
        send_rows(0, H, 1'b1);
        chk("rotated_result_count", nvalid[0], 784);
        chk("rotated_last_count", nlast[0], 1);

        // Stride 2 in both directions: 7x7 map.
        clear_stats();
        send_rows(1, H, 1'b0);
        chk("stride2_result_count", nvalid[1], 196);
        chk("stride2_last_count", nlast[1], 1);

        // Saturation: weights summing to 3000, -5000, 36, -36 over an all-ones window.
        fill_ones_img();
        for (int n = 0; n < N; n++) begin
            wt[0][n] = (n < N - 1) ? 83 : 95;
            wt[1][n] = (n < N - 1) ? -139 : -135;
            wt[2][n] = 1;
            wt[3][n] = -1;
        end
        set_fil();
        clear_stats();
        send_rows(0, L, 1'b0);
        chk("sat_result_count", nvalid[0], 56);
        chk("sat_pos_clamp", rlog[0].size() > 3 ? rlog[0][0] : -1, 2047);
        chk("sat_neg_clamp", rlog[0].size() > 3 ? rlog[0][1] : -1, -2048);
        chk("sat_plain_pos", rlog[0].size() > 3 ? rlog[0][2] : -1, 36);
        chk("sat_plain_neg", rlog[0].size() > 3 ? rlog[0][3] : -1, -36);
        clear_stats();
        send_rows(1, L, 1'b0);
        chk("relu_result_count", nvalid[1], 28);
        chk("relu_pos_clamp", rlog[1].size() > 3 ? rlog[1][0] : -1, 2047);
        chk("relu_neg_to_zero", rlog[1].size() > 3 ? rlog[1][1] : -1, 0);
        chk("relu_plain_pos", rlog[1].size() > 3 ? rlog[1][2] : -1, 36);
        chk("relu_small_neg", rlog[1].size() > 3 ? rlog[1][3] : -1, 0);

        // Reset on the second sweep cycle aborts everything in flight.
        fill_pattern();
        frame_pulse(0);
        send_col(0, 2, 1, 1'b1, 1'b1, 0);
        send_col(0, 2, 2, 1'b0, 1'b1, 0);
        send_col(0, 2, 3, 1'b0, 1'b1, 0);
        col_valid = 1'b0;
        chk("sweep_col_ready_low", int'(rdy[0]), 0);
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        chk("abort_col_ready", int'(rdy[0]), 1);
        chk("abort_result_valid", int'(rv[0]), 0);
        chk("abort_result_data", rd[0], 0);
        chk("abort_result_addr", ra[0], 0);
        chk("abort_result_k", rk[0], 0);
        chk("abort_last_val", int'(lv[0]), 0);
        q[0].delete(); q[1].delete();
        prev_elig = 1'b0;
        snap = nvalid[0] + nvalid[1];
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_result_pulses", nvalid[0] + nvalid[1] - snap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
